intr_src_cond: RTL and testbench
================================

// Module: intr_src_cond
// PURPOSE
//  Interrupt source conditioner sitting directly upstream of the priority interrupt controller.
//  Synchronises 16 raw peripheral interrupt lines and applies per-line polarity and level/edge
//  selection. Keeps sticky pending bits for edge sources and masks them. Drives the
//  controller's intr_active_i bus.
//  Clears edge-pending bits when the controller reports the serviced interrupt index.
//  Configured over the same APB-style register port used by the controller.
// PARAMETERS
//  NUM_INTR   16   number of interrupt lines (fixed 16 for this revision; index 4 bits)
//  SYNC_STAGES 2   synchroniser depth on intr_raw_i (>=2)
// PORTS
//  pclk_i             in   1   clock
//  prst_i             in   1   reset, asynchronous, active-high
//  paddr_i            in   4   register address
//  pwdata_i           in   16  write data
//  prdata_o           out  16  read data
//  penable_i          in   1   access enable
//  pwrite_i           in   1   1=write, 0=read
//  pready_o           out  1   access acknowledge
//  intr_raw_i         in   16  asynchronous raw peripheral interrupt lines
//  intr_to_service_i  in   4   index currently granted by controller
//  intr_serviced_i    in   1   1-cycle pulse: granted index has been serviced
//  intr_active_o      out  16  conditioned active vector to controller (pend & mask)
// BEHAVIOUR
//  Clock is pclk_i; reset is prst_i, asynchronous, active-high. Reset asserted at any time
//   clears all state immediately.
//  Reset values: prdata_o=0, pready_o=0, intr_active_o=0. MASK, TRIG, POL and PEND are 0.
//   Synchroniser and edge-history flops are 0.
//  Register map (word addr):
//   0x0 MASK: RW, 1=enabled.
//   0x1 TRIG: RW, 1=edge, 0=level.
//   0x2 POL: RW, 1=active-low/falling, 0=active-high/rising.
//   0x3 PEND: R; W1C applies to edge bits only.
//   0x4 RAW: R; returns the synchronised lines before polarity.
//   Other addresses: read 0, writes ignored.
//  Bus: on a rising edge with penable_i=1, pready_o<=1 and the access is performed that edge.
//   A write updates the register. A read loads prdata_o<=reg.
//   With penable_i=0, pready_o<=0 and prdata_o holds.
//  Sync: s = intr_raw_i delayed SYNC_STAGES flops. Condition c = s ^ POL.
//  Edge history: h <= c every cycle. An edge on line n fires when c[n]=1 and h[n]=0.
//  PEND per line n:
//   - Level (TRIG[n]=0): PEND[n] <= c[n] every cycle. W1C and serviced have no effect.
//   - Edge (TRIG[n]=1): set on edge.
//   - Edge, clear: on W1C bit n, or when intr_serviced_i=1 and intr_to_service_i==n.
//   - Edge, simultaneous set and clear in one cycle: set wins; the new edge is not lost.
//  intr_active_o = PEND & MASK, combinational from registered PEND/MASK.
//   Unmasked pending edge bits remain latched while masked and appear when unmasked.
//  Latency: raw edge captured by first sync flop at edge k -> PEND set at edge
//   k+SYNC_STAGES -> intr_active_o high after that edge (k+2 for default).
//  TRIG/POL write: for every line whose TRIG or POL bit changes, PEND[n] is cleared and
//   h[n] <= new c[n] that cycle, so no spurious edge fires. Unchanged lines are unaffected.
//  Pulse shorter than one pclk_i period may be missed (not guaranteed); pulses >=2 cycles
//   are always captured in edge mode.
//  Repeated edges before service collapse into one pending bit (no counting).
//  intr_serviced_i with a level-mode index is ignored; the line drops only when the source
//   deasserts.
// TESTING
//  T1 reset: hold prst_i high mid-traffic -> all outputs 0 within same cycle; MASK reads 0x0000 after release.
//  T2 level: MASK=0x0001, TRIG=0; raw[0]=1 at k -> intr_active_o=0x0001 after k+2; raw[0]=0 -> 0 after 2 cycles.
//  T3 edge+service: MASK=0x0020, TRIG=0x0020; 3-cycle pulse on raw[5] -> active=0x0020 stays after pulse; to_service=5, serviced=1 -> active=0 next cycle.
//  T4 set-vs-clear: edge on raw[3] reaches PEND in the same cycle as W1C 0x0008 -> PEND[3] stays 1.
//  T5 polarity: TRIG=0x0100, POL=0x0100, raw[8] idle high -> no pending on write; falling edge -> PEND=0x0100.
//  T6 bus: write MASK=0xA5A5, read addr 0x0 -> pready_o=1, prdata_o=0xA5A5; read addr 0x7 -> 0x0000.

Source files
------------

// File: rtl/intr_src_cond.sv
// Interrupt source conditioner: synchronises raw lines, applies polarity and level/edge
// selection, keeps masked sticky pending bits and feeds the interrupt controller.
module intr_src_cond #(
   parameter int NUM_INTR    = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                pclk_i,
   input  logic                prst_i,
   input  logic [3:0]          paddr_i,
   input  logic [15:0]         pwdata_i,
   output logic [15:0]         prdata_o,
   input  logic                penable_i,
   input  logic                pwrite_i,
   output logic                pready_o,
   input  logic [NUM_INTR-1:0] intr_raw_i,
   input  logic [3:0]          intr_to_service_i,
   input  logic                intr_serviced_i,
   output logic [NUM_INTR-1:0] intr_active_o
);

   localparam logic [3:0] ADDR_MASK = 4'h0;
   localparam logic [3:0] ADDR_TRIG = 4'h1;
   localparam logic [3:0] ADDR_POL  = 4'h2;
   localparam logic [3:0] ADDR_PEND = 4'h3;
   localparam logic [3:0] ADDR_RAW  = 4'h4;

   logic [SYNC_STAGES-1:0][NUM_INTR-1:0] sync_p;
   logic [NUM_INTR-1:0] mask_r;
   logic [NUM_INTR-1:0] trig_r;
   logic [NUM_INTR-1:0] pol_r;
   logic [NUM_INTR-1:0] pend_r;
   logic [NUM_INTR-1:0] hist_r;
   logic [15:0]         prdata_r;
   logic                pready_r;

   logic                wr_en;
   logic                rd_en;
   logic [NUM_INTR-1:0] sync_out;
   logic [NUM_INTR-1:0] cond;
   logic [NUM_INTR-1:0] edge_det;
   logic [NUM_INTR-1:0] trig_nxt;
   logic [NUM_INTR-1:0] pol_nxt;
   logic [NUM_INTR-1:0] cfg_chg;
   logic [NUM_INTR-1:0] w1c_clr;
   logic [NUM_INTR-1:0] svc_clr;
   logic [NUM_INTR-1:0] edge_clr;
   logic [NUM_INTR-1:0] pend_edge;
   logic [NUM_INTR-1:0] pend_nxt;
   logic [NUM_INTR-1:0] hist_nxt;
   logic [15:0]         rd_val;

   assign wr_en = penable_i & pwrite_i;
   assign rd_en = penable_i & ~pwrite_i;

   // Synchroniser: stage 0 samples the asynchronous lines
   always_ff @(posedge pclk_i or posedge prst_i) begin
      if (prst_i) begin
         sync_p <= '0;
      end else begin
         sync_p <= {sync_p[SYNC_STAGES-2:0], intr_raw_i};
      end
   end

   assign sync_out = sync_p[SYNC_STAGES-1];
   assign cond     = sync_out ^ pol_r;
   assign edge_det = cond & ~hist_r;

   assign trig_nxt = (wr_en && paddr_i == ADDR_TRIG) ? pwdata_i : trig_r;
   assign pol_nxt  = (wr_en && paddr_i == ADDR_POL)  ? pwdata_i : pol_r;
   assign cfg_chg  = (trig_nxt ^ trig_r) | (pol_nxt ^ pol_r);

   assign w1c_clr  = (wr_en && paddr_i == ADDR_PEND) ? pwdata_i : '0;
   assign svc_clr  = intr_serviced_i ? (NUM_INTR'(1) << intr_to_service_i) : '0;
   assign edge_clr = (w1c_clr | svc_clr) & trig_r;

   // A new edge overrides any clear arriving in the same cycle
   assign pend_edge = edge_det | (pend_r & ~edge_clr);
   assign pend_nxt  = ((trig_r & pend_edge) | (~trig_r & cond)) & ~cfg_chg;

   // Reloading history with the post-write condition suppresses edges caused by a
   // polarity flip; unchanged lines see pol_nxt == pol_r, i.e. plain h <= c
   assign hist_nxt = sync_out ^ pol_nxt;

   always_ff @(posedge pclk_i or posedge prst_i) begin
      if (prst_i) begin
         pend_r <= '0;
         hist_r <= '0;
         trig_r <= '0;
         pol_r  <= '0;
         mask_r <= '0;
      end else begin
         pend_r <= pend_nxt;
         hist_r <= hist_nxt;
         trig_r <= trig_nxt;
         pol_r  <= pol_nxt;
         if (wr_en && paddr_i == ADDR_MASK) begin
            mask_r <= pwdata_i;
         end
      end
   end

   always_comb begin
      rd_val = '0;
      case (paddr_i)
         ADDR_MASK: rd_val = mask_r;
         ADDR_TRIG: rd_val = trig_r;
         ADDR_POL:  rd_val = pol_r;
         ADDR_PEND: rd_val = pend_r;
         ADDR_RAW:  rd_val = sync_out;
         default:   rd_val = '0;
      endcase
   end

   always_ff @(posedge pclk_i or posedge prst_i) begin
      if (prst_i) begin
         pready_r <= 1'b0;
         prdata_r <= '0;
      end else begin
         pready_r <= penable_i;
         if (rd_en) begin
            prdata_r <= rd_val;
         end
      end
   end

   assign prdata_o      = prdata_r;
   assign pready_o      = pready_r;
   assign intr_active_o = pend_r & mask_r;

endmodule

// File: tb/tb_intr_src_cond.sv
// Self-checking bench for intr_src_cond: directed scenarios plus randomized traffic,
// compared every cycle against a rule-level behavioural model.
module tb_intr_src_cond;

   localparam int N  = 16;
   localparam int SS = 2;

   logic        pclk = 1'b0;
   logic        prst = 1'b1;
   logic [3:0]  paddr = '0;
   logic [15:0] pwdata = '0;
   logic [15:0] prdata;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic        pready;
   logic [15:0] raw = '0;
   logic [3:0]  svc_idx = '0;
   logic        svc = 1'b0;
   logic [15:0] active;

   int checks   = 0;
   int failures = 0;

   intr_src_cond #(.NUM_INTR(N), .SYNC_STAGES(SS)) dut (
      .pclk_i            (pclk),
      .prst_i            (prst),
      .paddr_i           (paddr),
      .pwdata_i          (pwdata),
      .prdata_o          (prdata),
      .penable_i         (penable),
      .pwrite_i          (pwrite),
      .pready_o          (pready),
      .intr_raw_i        (raw),
      .intr_to_service_i (svc_idx),
      .intr_serviced_i   (svc),
      .intr_active_o     (active)
   );

   always #5 pclk = ~pclk;

   // Model state
   logic [15:0] m_mask = '0, m_trig = '0, m_pol = '0, m_pend = '0, m_hist = '0;
   logic [15:0] m_prdata = '0;
   logic        m_pready = 1'b0;
   logic [15:0] m_dly [SS];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] m_read(input logic [3:0] a);
      case (a)
         4'h0: return m_mask;
         4'h1: return m_trig;
         4'h2: return m_pol;
         4'h3: return m_pend;
         4'h4: return m_dly[SS-1];
         default: return 16'h0000;
      endcase
   endfunction

   // Behavioural model: raw lines pass through a SS-deep delay line, then the rules apply per line
   initial begin
      for (int i = 0; i < SS; i++) m_dly[i] = '0;
      forever begin
         @(posedge pclk or posedge prst);
         if (prst) begin
            m_mask = '0; m_trig = '0; m_pol = '0; m_pend = '0; m_hist = '0;
            m_prdata = '0; m_pready = 1'b0;
            for (int i = 0; i < SS; i++) m_dly[i] = '0;
         end else begin
            logic [15:0] s, c, t_new, p_new, pend_n, hist_n;
            s = m_dly[SS-1];
            c = s ^ m_pol;
            t_new = (penable && pwrite && paddr == 4'h1) ? pwdata : m_trig;
            p_new = (penable && pwrite && paddr == 4'h2) ? pwdata : m_pol;
            for (int n = 0; n < N; n++) begin
               if (t_new[n] != m_trig[n] || p_new[n] != m_pol[n]) begin
                  pend_n[n] = 1'b0;
                  hist_n[n] = s[n] ^ p_new[n];
               end else begin
                  hist_n[n] = c[n];
                  if (!m_trig[n])
                     pend_n[n] = c[n];
                  else if (c[n] && !m_hist[n])
                     pend_n[n] = 1'b1;
                  else if ((penable && pwrite && paddr == 4'h3 && pwdata[n]) ||
                           (svc && int'(svc_idx) == n))
                     pend_n[n] = 1'b0;
                  else
                     pend_n[n] = m_pend[n];
               end
            end
            if (penable) begin
               m_pready = 1'b1;
               if (!pwrite) m_prdata = m_read(paddr);
               else if (paddr == 4'h0) m_mask = pwdata;
            end else begin
               m_pready = 1'b0;
            end
            m_trig = t_new;
            m_pol  = p_new;
            m_pend = pend_n;
            m_hist = hist_n;
            for (int i = SS-1; i > 0; i--) m_dly[i] = m_dly[i-1];
            m_dly[0] = raw;
         end
      end
   end

   // Continuous comparison on the falling edge, away from the active edge
   initial begin
      forever begin
         @(negedge pclk);
         chk("active", active, m_pend & m_mask);
         chk("pready", {15'd0, pready}, {15'd0, m_pready});
         chk("prdata", prdata, m_prdata);
      end
   end

   task automatic tick();
      @(posedge pclk);
      #2;
   endtask

   task automatic bus_wr(input logic [3:0] a, input logic [15:0] d);
      paddr = a; pwdata = d; pwrite = 1'b1; penable = 1'b1;
      tick();
      penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic bus_rd(input logic [3:0] a);
      paddr = a; pwrite = 1'b0; penable = 1'b1;
      tick();
      penable = 1'b0;
   endtask

   initial begin
      tick();
      tick();
      prst = 1'b0;
      tick();

      // T1: reset mid-traffic
      bus_wr(4'h0, 16'hFFFF);
      raw = 16'h00F0;
      repeat (3) tick();
      chk("t1_pre_active", active, 16'h00F0);
      paddr = 4'h0; pwrite = 1'b0; penable = 1'b1;
      tick();
      chk("t1_pre_prdata", prdata, 16'hFFFF);
      #1 prst = 1'b1;
      #1;
      chk("t1_rst_active", active, 16'h0000);
      chk("t1_rst_pready", {15'd0, pready}, 16'h0000);
      chk("t1_rst_prdata", prdata, 16'h0000);
      penable = 1'b0;
      raw = '0;
      tick();
      tick();
      prst = 1'b0;
      tick();
      bus_rd(4'h0);
      chk("t1_mask_after", prdata, 16'h0000);

      // T2: level mode
      bus_wr(4'h0, 16'h0001);
      bus_wr(4'h1, 16'h0000);
      raw = 16'h0001;
      tick();
      tick();
      chk("t2_k1", active, 16'h0000);
      tick();
      chk("t2_k2", active, 16'h0001);
      chk("t2_model", m_pend & m_mask, 16'h0001);
      raw = 16'h0000;
      tick();
      tick();
      chk("t2_fall_k1", active, 16'h0001);
      tick();
      chk("t2_fall_k2", active, 16'h0000);

      // T3: edge capture and service
      bus_wr(4'h0, 16'h0020);
      bus_wr(4'h1, 16'h0020);
      raw = 16'h0020;
      repeat (3) tick();
      raw = 16'h0000;
      repeat (3) tick();
      chk("t3_latched", active, 16'h0020);
      chk("t3_model", m_pend & m_mask, 16'h0020);
      svc_idx = 4'd5; svc = 1'b1;
      tick();
      svc = 1'b0;
      chk("t3_serviced", active, 16'h0000);

      // T4: set wins over simultaneous W1C
      bus_wr(4'h0, 16'h0008);
      bus_wr(4'h1, 16'h0008);
      raw = 16'h0008;
      tick();
      tick();
      bus_wr(4'h3, 16'h0008);
      chk("t4_set_wins", active, 16'h0008);
      bus_wr(4'h3, 16'h0008);
      chk("t4_w1c", active, 16'h0000);
      raw = 16'h0000;

      // T5: falling-edge polarity, no spurious pending on configuration
      raw = 16'h0100;
      repeat (3) tick();
      bus_wr(4'h1, 16'h0100);
      bus_wr(4'h2, 16'h0100);
      bus_wr(4'h0, 16'h0100);
      tick();
      tick();
      chk("t5_no_spurious", active, 16'h0000);
      bus_rd(4'h3);
      chk("t5_pend_read", prdata, 16'h0000);
      raw = 16'h0000;
      tick();
      tick();
      tick();
      chk("t5_fall", active, 16'h0100);

      // T6: bus
      bus_wr(4'h0, 16'hA5A5);
      bus_rd(4'h0);
      chk("t6_pready", {15'd0, pready}, 16'h0001);
      chk("t6_mask", prdata, 16'hA5A5);
      bus_wr(4'h7, 16'hFFFF);
      bus_rd(4'h7);
      chk("t6_unmapped", prdata, 16'h0000);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [15:0] flip;
         for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 7) == 0);
         raw = raw ^ flip;
         if ($urandom_range(0, 9) < 3) begin
            paddr   = 4'($urandom_range(0, 7));
            pwrite  = 1'($urandom_range(0, 1));
            pwdata  = 16'($urandom);
            penable = 1'b1;
         end else begin
            penable = 1'b0;
         end
         svc     = ($urandom_range(0, 4) == 0);
         svc_idx = 4'($urandom_range(0, 15));
         if (i == 1500) begin
            #1 prst = 1'b1;
            tick();
            tick();
            prst = 1'b0;
         end
         tick();
      end
      penable = 1'b0;
      svc = 1'b0;
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
